// File: rtl/flash_arbiter_if.sv
// Client and flash_manager signals of flash_arbiter, grouped into one bundle.
// The master side is the arbiter. The slave side is the clients plus the flash_manager.
interface flash_arbiter_if;
  logic        busy;
  logic [15:0] frdata;
  logic        writemode;
  logic        dowrite;
  logic        doread;
  logic [15:0] wdata;
  logic [22:0] raddr;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        rd0_req;
  logic        rd1_req;
  logic [22:0] rd0_addr;
  logic [22:0] rd1_addr;
  logic        rd0_ack;
  logic        rd1_ack;
  logic [15:0] rd0_data;
  logic [15:0] rd1_data;
  logic [1:0]  owner;
  logic        timeout_err;

  modport master (
    input  busy, frdata, wr_req, wr_data, rd0_req, rd1_req, rd0_addr, rd1_addr,
    output writemode, dowrite, doread, wdata, raddr, wr_ack, rd0_ack, rd1_ack,
           rd0_data, rd1_data, owner, timeout_err
  );

  modport slave (
    output busy, frdata, wr_req, wr_data, rd0_req, rd1_req, rd0_addr, rd1_addr,
    input  writemode, dowrite, doread, wdata, raddr, wr_ack, rd0_ack, rd1_ack,
           rd0_data, rd1_data, owner, timeout_err
  );
endinterface

// File: rtl/flash_arbiter.sv
// Shares one flash_manager port between a write client and two read clients.
// The arbiter runs one op at a time, settles writemode after each change, and aborts hung ops.
module flash_arbiter #(
  parameter int unsigned MODE_SETTLE    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic            clock,
  input logic            reset,
  flash_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SET_W = $clog2(MODE_SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(MODE_SETTLE - 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WR   = 2'd1;
  localparam logic [1:0] OWN_RD0  = 2'd2;
  localparam logic [1:0] OWN_RD1  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_ARM, S_WAIT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic             mode_q, mode_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [22:0]      raddr_q, raddr_d;
  logic [15:0]      rd0_data_q, rd0_data_d;
  logic [15:0]      rd1_data_q, rd1_data_d;
  logic             to_err_q, to_err_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic             last_rd_q, last_rd_d;   // 1: rd1 was the read served most recently
  logic             last_wr_q, last_wr_d;   // 1: the previous grant went to the writer

  logic             rd_any;
  logic             grant_wr;
  logic             pick_rd1;
  logic [1:0]       grant_own;
  logic [CNT_W-1:0] wd_inc;

  // The writer yields once to a pending read, so writes and reads alternate.
  assign rd_any   = bus.rd0_req | bus.rd1_req;
  assign grant_wr = bus.wr_req & ~(last_wr_q & rd_any);
  assign pick_rd1 = bus.rd1_req & (~bus.rd0_req | ~last_rd_q);
  assign wd_inc   = wd_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mode_d     = mode_q;
    wdata_d    = wdata_q;
    raddr_d    = raddr_q;
    rd0_data_d = rd0_data_q;
    rd1_data_d = rd1_data_q;
    to_err_d   = to_err_q;
    wd_cnt_d   = wd_cnt_q;
    set_cnt_d  = set_cnt_q;
    last_rd_d  = last_rd_q;
    last_wr_d  = last_wr_q;
    grant_own  = OWN_NONE;

    case (state_q)
      S_IDLE: begin
        if (!bus.busy) begin
          if (grant_wr) begin
            grant_own = OWN_WR;
            wdata_d   = bus.wr_data;
          end else if (rd_any) begin
            grant_own = pick_rd1 ? OWN_RD1 : OWN_RD0;
            raddr_d   = pick_rd1 ? bus.rd1_addr : bus.rd0_addr;
          end
          if (grant_own != OWN_NONE) begin
            owner_d   = grant_own;
            last_wr_d = (grant_own == OWN_WR);
            set_cnt_d = '0;
            if ((grant_own == OWN_WR) != mode_q) begin
              mode_d  = (grant_own == OWN_WR);
              state_d = S_SETUP;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_SETUP: begin
        if (set_cnt_q == SET_LAST) begin
          state_d = S_ISSUE;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.busy) begin
          if (owner_q == OWN_RD0) rd0_data_d = bus.frdata;
          if (owner_q == OWN_RD1) rd1_data_d = bus.frdata;
          state_d = S_DONE;
        end else begin
          wd_cnt_d = wd_inc;
          if (wd_inc == CNT_MAX) begin
            to_err_d = 1'b1;
            if (owner_q == OWN_RD0) rd0_data_d = 16'h0000;
            if (owner_q == OWN_RD1) rd1_data_d = 16'h0000;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (owner_q == OWN_RD0) last_rd_d = 1'b0;
        if (owner_q == OWN_RD1) last_rd_d = 1'b1;
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_NONE;
      mode_q     <= 1'b0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      rd0_data_q <= '0;
      rd1_data_q <= '0;
      to_err_q   <= 1'b0;
      wd_cnt_q   <= '0;
      set_cnt_q  <= '0;
      last_rd_q  <= 1'b1;
      last_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mode_q     <= mode_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
      rd0_data_q <= rd0_data_d;
      rd1_data_q <= rd1_data_d;
      to_err_q   <= to_err_d;
      wd_cnt_q   <= wd_cnt_d;
      set_cnt_q  <= set_cnt_d;
      last_rd_q  <= last_rd_d;
      last_wr_q  <= last_wr_d;
    end
  end

  // Pulses decode from the state register, so a reset cuts them on the next edge.
  assign bus.dowrite     = (state_q == S_ISSUE) && (owner_q == OWN_WR);
  assign bus.doread      = (state_q == S_ISSUE) && owner_q[1];
  assign bus.wr_ack      = (state_q == S_DONE) && (owner_q == OWN_WR);
  assign bus.rd0_ack     = (state_q == S_DONE) && (owner_q == OWN_RD0);
  assign bus.rd1_ack     = (state_q == S_DONE) && (owner_q == OWN_RD1);
  assign bus.writemode   = mode_q;
  assign bus.wdata       = wdata_q;
  assign bus.raddr       = raddr_q;
  assign bus.rd0_data    = rd0_data_q;
  assign bus.rd1_data    = rd1_data_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = to_err_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: a scripted flash_manager model plus scenario tasks.
// Expected grants and latencies come from a transaction-level model of the arbitration rules.
module tb_flash_arbiter;
  localparam int MS = 4;
  localparam int TO = 20;

  logic clock = 1'b0;
  logic reset;
  flash_arbiter_if bus();

  flash_arbiter #(.MODE_SETTLE(MS), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // flash_manager model: busy for cur_lat WAIT cycles after a pulse, or forever while hung
  bit   hung;
  int   cur_lat;
  int   fcnt;
  logic fbusy;
  assign bus.busy = fbusy;

  function automatic logic [15:0] mem(input logic [22:0] a);
    if (a == 23'h000123) return 16'hBEEF;
    return a[15:0] ^ {a[22:16], 9'h0A5};
  endfunction

  initial begin
    fbusy = 1'b0;
    fcnt = 0;
    bus.frdata = 16'h0;
    forever begin
      @(negedge clock);
      if (reset) begin
        fbusy = 1'b0;
        fcnt = 0;
      end else if (bus.doread || bus.dowrite) begin
        bus.frdata = mem(bus.raddr);
        if (hung) fbusy = 1'b1;
        else if (cur_lat > 0) begin
          fbusy = 1'b1;
          fcnt = cur_lat + 2;
        end
      end else if (fbusy && !hung) begin
        if (fcnt > 0) fcnt--;
        if (fcnt == 0) fbusy = 1'b0;
      end
    end
  end

  int          obs_pulse, obs_ack, obs_mode, obs_npulse;
  logic [1:0]  obs_who, obs_own;
  logic [15:0] obs_rdat, obs_wdat;
  logic [22:0] obs_raddr;
  bit          obs_both;

  task automatic set_req(input logic [2:0] ports, input logic [22:0] a0, input logic [22:0] a1,
                         input logic [15:0] wd);
    bus.wr_req   = ports[0];
    bus.rd0_req  = ports[1];
    bus.rd1_req  = ports[2];
    bus.rd0_addr = a0;
    bus.rd1_addr = a1;
    bus.wr_data  = wd;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    set_req(3'b000, 23'h0, 23'h0, 16'h0);
    hung = 1'b0;
    cur_lat = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Watches until the next ack (bounded); offsets count negedges from the call.
  task automatic watch(input int lat, input bit drop);
    logic prev_mode;
    cur_lat = lat;
    obs_pulse = -1; obs_ack = -1; obs_mode = -1; obs_npulse = 0;
    obs_who = 2'd0; obs_own = 2'd0; obs_rdat = 16'h0; obs_wdat = 16'h0;
    obs_raddr = 23'h0; obs_both = 1'b0;
    prev_mode = bus.writemode;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (bus.writemode !== prev_mode && obs_mode < 0) obs_mode = i;
      if (bus.doread || bus.dowrite) begin
        obs_npulse++;
        if (bus.doread && bus.dowrite) obs_both = 1'b1;
        if (obs_pulse < 0) begin
          obs_pulse = i; obs_own = bus.owner; obs_raddr = bus.raddr; obs_wdat = bus.wdata;
        end
      end
      if (bus.wr_ack || bus.rd0_ack || bus.rd1_ack) begin
        obs_ack  = i;
        obs_who  = bus.wr_ack ? 2'd1 : (bus.rd0_ack ? 2'd2 : 2'd3);
        obs_rdat = bus.rd0_ack ? bus.rd0_data : bus.rd1_data;
        if (drop) set_req(3'b000, bus.rd0_addr, bus.rd1_addr, bus.wr_data);
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.writemode, bus.dowrite, bus.doread, bus.wr_ack, bus.rd0_ack, bus.rd1_ack,
         bus.timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {bus.writemode, bus.dowrite, bus.doread,
               bus.wr_ack, bus.rd0_ack, bus.rd1_ack, bus.timeout_err});
    end
    checks++;
    if ({bus.wdata, bus.raddr, bus.rd0_data, bus.rd1_data} !== 71'b0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%h want 0", bus.wdata, bus.raddr, bus.rd0_data,
               bus.rd1_data);
    end
    checks++;
    if (bus.owner !== 2'd0) begin
      errors++; $display("FAIL reset_owner got %0d want 0", bus.owner);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clock);
    set_req(3'b010, 23'h000123, 23'h0, 16'h0);
    watch(0, 1'b1);
    checks++;
    if (obs_mode != -1 || bus.writemode !== 1'b0) begin
      errors++; $display("FAIL rd_mode got change@%0d wm=%b want none/0", obs_mode, bus.writemode);
    end
    checks++;
    if (obs_pulse != 1 || obs_ack != 4) begin
      errors++; $display("FAIL rd_latency got pulse %0d ack %0d want 1 4", obs_pulse, obs_ack);
    end
    checks++;
    if (obs_raddr !== 23'h000123 || obs_own !== 2'd2 || obs_who !== 2'd2) begin
      errors++; $display("FAIL rd_grant got addr %h own %0d ack %0d want 123 2 2", obs_raddr,
                         obs_own, obs_who);
    end
    checks++;
    if (obs_rdat !== 16'hBEEF) begin
      errors++; $display("FAIL rd_data got %h want BEEF", obs_rdat);
    end
    @(negedge clock);
    checks++;
    if (bus.owner !== 2'd0 || bus.rd0_data !== 16'hBEEF) begin
      errors++; $display("FAIL rd_after got owner %0d data %h want 0 BEEF", bus.owner,
                         bus.rd0_data);
    end
  endtask

  task automatic test_write();
    do_reset();
    @(negedge clock);
    set_req(3'b001, 23'h0, 23'h0, 16'h00A5);
    watch(0, 1'b1);
    checks++;
    if (obs_mode != 1 || obs_pulse != 1 + MS || obs_ack != 4 + MS) begin
      errors++; $display("FAIL wr_latency got mode %0d pulse %0d ack %0d want 1 5 8", obs_mode,
                         obs_pulse, obs_ack);
    end
    checks++;
    if (obs_wdat !== 16'h00A5 || obs_own !== 2'd1 || obs_who !== 2'd1 || obs_npulse != 1
        || obs_both) begin
      errors++; $display("FAIL wr_op got wdata %h own %0d ack %0d pulses %0d", obs_wdat, obs_own,
                         obs_who, obs_npulse);
    end
    do_reset();
    @(negedge clock);
    set_req(3'b001, 23'h0, 23'h0, 16'h5A00);
    watch(10, 1'b1);
    checks++;
    if (obs_ack != 14 + MS || obs_who !== 2'd1) begin
      errors++; $display("FAIL wr_busy10 got ack %0d port %0d want 18 1", obs_ack, obs_who);
    end
  endtask

  task automatic test_read_tie();
    logic [22:0] a0, a1;
    int lr, exp_who;
    do_reset();
    a0 = 23'($urandom); a1 = 23'($urandom);
    lr = 1;
    @(negedge clock);
    set_req(3'b110, a0, a1, 16'h0);
    for (int k = 0; k < 3; k++) begin
      watch(int'($urandom_range(0, 2)), k == 2);
      exp_who = (lr == 1) ? 2 : 3;
      lr = (exp_who == 3) ? 1 : 0;
      checks++;
      if (obs_who !== 2'(exp_who) || obs_rdat !== mem(exp_who == 2 ? a0 : a1)) begin
        errors++; $display("FAIL tie_%0d got port %0d data %h want %0d %h", k, obs_who, obs_rdat,
                           exp_who, mem(exp_who == 2 ? a0 : a1));
      end
    end
  endtask

  task automatic test_wr_rd_contention();
    int exp_who;
    bit pw;
    do_reset();
    pw = 1'b0;
    @(negedge clock);
    set_req(3'b101, 23'h0, 23'h00ABCD, 16'h1357);
    for (int k = 0; k < 4; k++) begin
      watch(0, k == 3);
      exp_who = pw ? 3 : 1;
      pw = (exp_who == 1);
      checks++;
      if (obs_who !== 2'(exp_who) || obs_mode < 0 || obs_pulse - obs_mode != MS) begin
        errors++; $display("FAIL contend_%0d got port %0d settle %0d want %0d %0d", k, obs_who,
                           obs_pulse - obs_mode, exp_who, MS);
      end
    end
  endtask

  task automatic test_hung();
    int bad;
    do_reset();
    @(negedge clock);
    set_req(3'b010, 23'h0456A, 23'h0, 16'h0);
    watch(1, 1'b1);
    checks++;
    if (obs_rdat !== mem(23'h0456A) || obs_ack != 5) begin
      errors++; $display("FAIL hung_pre got data %h ack %0d want %h 5", obs_rdat, obs_ack,
                         mem(23'h0456A));
    end
    hung = 1'b1;
    @(negedge clock);
    set_req(3'b010, 23'h0777, 23'h0, 16'h0);
    watch(0, 1'b1);
    checks++;
    if (obs_ack != 3 + TO || obs_who !== 2'd2 || obs_rdat !== 16'h0) begin
      errors++; $display("FAIL hung_abort got ack %0d port %0d data %h want %0d 2 0", obs_ack,
                         obs_who, obs_rdat, 3 + TO);
    end
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++; $display("FAIL hung_flag got %b want 1", bus.timeout_err);
    end
    @(negedge clock);
    set_req(3'b100, 23'h0, 23'h02468, 16'h0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.doread || bus.dowrite || bus.owner != 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL busy_gate got %0d active cycles want 0", bad);
    end
    hung = 1'b0;
    watch(0, 1'b1);
    checks++;
    if (obs_who !== 2'd3 || obs_rdat !== mem(23'h02468) || bus.timeout_err !== 1'b1) begin
      errors++; $display("FAIL hung_resume got port %0d data %h flag %b want 3 %h 1", obs_who,
                         obs_rdat, bus.timeout_err, mem(23'h02468));
    end
  endtask

  task automatic test_reset_in_wait();
    int acks;
    do_reset();
    @(negedge clock);
    set_req(3'b001, 23'h0, 23'h0, 16'h1234);
    cur_lat = 10;
    acks = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      if (bus.wr_ack) acks++;
    end
    reset = 1'b1;
    bus.wr_req = 1'b0;
    @(negedge clock);
    if (bus.wr_ack) acks++;
    checks++;
    if ({bus.writemode, bus.dowrite, bus.doread, bus.timeout_err, bus.owner} !== 6'b0 ||
        {bus.wdata, bus.raddr, bus.rd0_data, bus.rd1_data} !== 71'b0) begin
      errors++; $display("FAIL rst_wait_out got wm %b own %0d wdata %h rd1 %h want 0",
                         bus.writemode, bus.owner, bus.wdata, bus.rd1_data);
    end
    @(negedge clock);
    reset = 1'b0;
    set_req(3'b100, 23'h0, 23'h0AAAA, 16'h0);
    watch(1, 1'b1);
    if (obs_ack > 0 && obs_who == 2'd1) acks++;
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL rst_wait_noack got %0d wr_ack want 0", acks);
    end
    checks++;
    if (obs_who !== 2'd3 || obs_ack != 5 || obs_mode != -1 || obs_rdat !== mem(23'h0AAAA)) begin
      errors++; $display("FAIL rst_wait_next got port %0d ack %0d data %h want 3 5 %h", obs_who,
                         obs_ack, obs_rdat, mem(23'h0AAAA));
    end
  endtask

  task automatic test_random();
    logic [2:0]  ports;
    logic [22:0] a0, a1;
    logic [15:0] wd;
    int lat, win, exp_pulse;
    bit m_prev_wr, m_last_rd1, m_mode, change;
    do_reset();
    m_prev_wr = 1'b0; m_last_rd1 = 1'b1; m_mode = 1'b0;
    for (int n = 0; n < 30; n++) begin
      ports = 3'($urandom_range(1, 7));
      a0 = 23'($urandom); a1 = 23'($urandom); wd = 16'($urandom);
      lat = int'($urandom_range(0, 3));
      if (ports[0] && !(m_prev_wr && (ports[1] || ports[2]))) win = 1;
      else if (ports[1] && ports[2]) win = m_last_rd1 ? 2 : 3;
      else win = ports[1] ? 2 : 3;
      change = ((win == 1) != m_mode);
      exp_pulse = 1 + (change ? MS : 0);
      m_mode = (win == 1);
      m_prev_wr = (win == 1);
      if (win == 2) m_last_rd1 = 1'b0;
      if (win == 3) m_last_rd1 = 1'b1;
      @(negedge clock);
      set_req(ports, a0, a1, wd);
      watch(lat, 1'b1);
      checks++;
      if (obs_who !== 2'(win) || obs_pulse != exp_pulse || obs_ack != exp_pulse + 3 + lat ||
          obs_npulse != 1 || obs_both) begin
        errors++; $display("FAIL rand_%0d got port %0d pulse %0d ack %0d n %0d want %0d %0d %0d",
                           n, obs_who, obs_pulse, obs_ack, obs_npulse, win, exp_pulse,
                           exp_pulse + 3 + lat);
      end
      checks++;
      if (win == 1 ? (obs_wdat !== wd) :
          (obs_raddr !== (win == 2 ? a0 : a1) || obs_rdat !== mem(win == 2 ? a0 : a1))) begin
        errors++; $display("FAIL rand_data_%0d got wd %h addr %h rd %h", n, obs_wdat, obs_raddr,
                           obs_rdat);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    hung = 1'b0;
    cur_lat = 0;
    set_req(3'b000, 23'h0, 23'h0, 16'h0);
    test_reset();
    test_single_read();
    test_write();
    test_read_tie();
    test_wr_rd_contention();
    test_hung();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Sequencer and arbiter that shares the single `flash_manager` port between one sequential write client and two random-access read clients. It sits between the client logic (USB loader on the write port; playback/display readers on the read ports) and `flash_manager`. It issues one flash operation at a time, handles `writemode` switching with a settle interval, and detects hung operations with a watchdog.

## Interface
- `MODE_SETTLE`, 4: idle cycles inserted after `writemode` changes, before the op pulse (≥1).
- `TIMEOUT_CYCLES`, 1000000: maximum WAIT cycles with `busy` high before the op is aborted.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `busy` in 1: from `flash_manager`.
- `frdata` in 16: read data from `flash_manager`.
- `writemode` out 1: to `flash_manager`.
- `dowrite` out 1: to `flash_manager`.
- `doread` out 1: to `flash_manager`.
- `wdata` out 16: to `flash_manager`.
- `raddr` out 23: to `flash_manager`.
- `wr_req` in 1: write request, level.
- `wr_data` in 16: write word.
- `wr_ack` out 1: one-cycle completion pulse.
- `rd0_req`, `rd1_req` in 1: read requests, level.
- `rd0_addr`, `rd1_addr` in 23: word addresses.
- `rd0_ack`, `rd1_ack` out 1: one-cycle completion pulses.
- `rd0_data`, `rd1_data` out 16: read word, valid while the matching ack is high, held afterwards.
- `owner` out 2: current grant. 0 = none, 1 = wr, 2 = rd0, 3 = rd1.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States: IDLE, SETUP, ISSUE, ARM, WAIT, DONE.
- **IDLE:** requests are sampled only here and only when `busy`=0. Grant priority:
  - `wr` wins over reads, except when the previous grant was `wr` and a read is pending. In that case the read is served, so writes and reads alternate.
  - Between reads, round-robin. `last_rd` points to the read port served most recently; the other port wins a tie. `last_rd` resets to rd1, so rd0 wins the first tie.
- **On grant:**
  - Latch `wr_data`→`wdata` or `rdN_addr`→`raddr`.
  - Set `owner`.
  - Required mode is 1 for `wr`, 0 for reads. If it differs from `writemode`, update `writemode` and go to SETUP; otherwise go to ISSUE.
- **SETUP:** counts `MODE_SETTLE` cycles, then goes to ISSUE.
- **ISSUE:** `dowrite` (for `wr`) or `doread` (for reads) is high for exactly this one cycle. Next state is ARM.
- **ARM:** one cycle with `busy` ignored, covering `flash_manager` busy-rise latency. Next state is WAIT.
- **WAIT:**
  - Stays while `busy`=1, incrementing the watchdog counter.
  - On `busy`=0, capture `frdata` into `rdN_data` (reads only) and go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES` with `busy` still 1: set `timeout_err`, set `rdN_data`=16'h0000 for reads, and go to DONE.
- **DONE:** assert the matching ack for one cycle, set `owner`←0, update `last_rd` if a read was served, and go to IDLE.
- `writemode` is a level. It is held between ops and changes only on grant.
- `wdata` and `raddr` are held after the op.
- Clients must drop `req` in the cycle after ack. Clearing `req` on a registered ack meets this. `req` still high in IDLE is treated as a new request.
- Client address and data need to be valid only in the IDLE grant cycle.

## Timing
- **Reset values:** `writemode`=0, `dowrite`=`doread`=0, `wdata`=0, `raddr`=0, all acks 0, `rd0_data`=`rd1_data`=0, `owner`=0, `timeout_err`=0, state IDLE, watchdog counter 0.
- **Reset mid-operation:** the transaction is dropped and no ack is issued. Any in-progress `dowrite`/`doread` pulse is cut to 0 on the next edge.
- **Latency, grant in IDLE at cycle T, no mode change:** ISSUE at T+1, ARM at T+2, first WAIT at T+3, ack at T+4 when `busy` is already 0 at T+3. Each additional busy cycle adds 1.
- **Latency with a mode change:** adds `MODE_SETTLE` cycles before ISSUE.
- **Back-to-back ops:** the next grant can occur in the IDLE cycle immediately after DONE. Minimum spacing between op pulses is 5 cycles.
- **Gating:** `busy`=1 while in IDLE blocks granting, even if requests are pending.
- **Overlap:** at most one `dowrite`/`doread` pulse per transaction, and the two are never high together.
- **Watchdog:** the counter is wide enough for `TIMEOUT_CYCLES` and clears on entry to WAIT. `timeout_err` clears only on reset.

## Test plan
- **Single read, busy low throughout:**
  - Stimulus: `rd0_req`, `rd0_addr`=23'h000123, `frdata`=16'hBEEF.
  - Response: `writemode` 0 with no SETUP, `raddr`=23'h000123, `doread` pulse at T+1, `rd0_ack` at T+4 with `rd0_data`=16'hBEEF, `owner` sequence 2 then 0.
- **Write after reset:**
  - Stimulus: `wr_req`, `wr_data`=16'h00A5, `MODE_SETTLE`=4.
  - Response: `writemode` rises at T+1, `dowrite` pulse at T+5, `wr_ack` at T+8. With `busy` held for 10 cycles after ARM, `wr_ack` moves to T+18.
- **Read tie:**
  - Stimulus: `rd0_req` and `rd1_req` held continuously.
  - Response: grants alternate rd0, rd1, rd0, with rd0 first after reset, and each ack matches its own address's data.
- **Write/read contention:**
  - Stimulus: `wr_req` and `rd1_req` held.
  - Response: grant order is wr, rd1, wr, rd1, with a SETUP interval before every op because the mode flips each time.
- **Hung flash:**
  - Stimulus: `TIMEOUT_CYCLES`=20, `busy` stuck at 1 after a read ISSUE.
  - Response: `rd0_ack` after 20 WAIT cycles with `rd0_data`=0. `timeout_err` becomes 1 and stays 1. The next request is blocked while `busy`=1 and proceeds once `busy` falls.
- **Reset in WAIT:**
  - Stimulus: synchronous `reset` during a write.
  - Response: no `wr_ack`, all outputs return to their reset values on the next edge, and the next `rd1_req` is served normally.
